// File: rtl/dram_arbiter_if.sv
// Request/response bundle shared by the two requesters, the memory and the
// arbiter. The "master" view belongs to the environment: both requesters
// and the memory's read-data return. The "slave" view belongs to the
// arbiter.
interface dram_arbiter_if;
  // Data port: reads and writes
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  // Fetch port: reads only
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [63:0] i_rdata;
  // Memory side
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_rdata;

  modport master (
    output d_req, d_we, d_addr, d_wdata, d_wstrb, i_req, i_addr, mem_rdata,
    input  d_gnt, d_rvalid, d_rdata, i_gnt, i_rvalid, i_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, d_wstrb, i_req, i_addr, mem_rdata,
    output d_gnt, d_rvalid, d_rdata, i_gnt, i_rvalid, i_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of a single fixed-latency memory. The data port
// normally wins; a starvation counter hands the memory to the fetch port
// after STARVE_MAX consecutive data grants. At most one read is in flight:
// IDLE grants, WAIT counts down the memory latency, RESP returns the data.
module dram_arbiter #(
  parameter int unsigned MEM_LAT    = 1,  // cycles from mem_en to mem_rdata, 1..15
  parameter int unsigned STARVE_MAX = 4   // data grants allowed while fetch waits
) (
  input  logic           clk,
  input  logic           rst,
  dram_arbiter_if.slave  bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {OWN_D, OWN_I} owner_e;

  state_e         state_q,      state_d;
  owner_e         owner_q,      owner_d;
  logic [SW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [3:0]     lat_cnt_q,    lat_cnt_d;
  logic [63:0]    rdata_q,      rdata_d;

  logic d_grant;
  logic i_grant;

  // Arbitration: one grant at most, only in IDLE and never during reset
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    d_grant = 1'b0;
    i_grant = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (bus.i_req && (!bus.d_req || starve_cnt_q == SW'(STARVE_MAX)))
        i_grant = 1'b1;
      else if (bus.d_req)
        d_grant = 1'b1;
    end
  end

  // Memory strobe and fields follow the granted port straight through
  always_comb begin
    bus.mem_en    = d_grant | i_grant;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    if (d_grant) begin
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_wstrb = bus.d_we ? bus.d_wstrb : 8'h00;
    end else if (i_grant) begin
      bus.mem_addr  = bus.i_addr;
    end
  end

  // Next-state: read tracking, latency countdown, capture and fairness count
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    rdata_d      = rdata_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      IDLE: begin
        // Writes finish in their grant cycle; only reads leave IDLE
        if ((d_grant && !bus.d_we) || i_grant) begin
          owner_d   = i_grant ? OWN_I : OWN_D;
          lat_cnt_d = 4'(MEM_LAT - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Fetch is "waiting" only while it actually requests
    if (!bus.i_req || i_grant)
      starve_cnt_d = '0;
    else if (d_grant)
      starve_cnt_d = starve_cnt_q + SW'(1);
  end

  // State register with synchronous reset; an in-flight read is dropped
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_D;
      lat_cnt_q    <= '0;
      rdata_q      <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      rdata_q      <= rdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Responses: grants, one-cycle rvalid to the owner, shared read data
  always_comb begin
    bus.d_gnt    = d_grant;
    bus.i_gnt    = i_grant;
    bus.d_rvalid = !rst && state_q == RESP && owner_q == OWN_D;
    bus.i_rvalid = !rst && state_q == RESP && owner_q == OWN_I;
    bus.d_rdata  = rdata_q;
    bus.i_rdata  = rdata_q;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter. Instance a runs MEM_LAT=1, instance b
// runs MEM_LAT=3; both use STARVE_MAX=4. Inputs change 1 time unit after
// the rising edge and outputs are compared 1 unit later, mid-cycle.
module tb_dram_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dram_arbiter_if ifa ();
  dram_arbiter_if ifb ();

  dram_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dram_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifa.d_req = 0; ifa.d_we = 0; ifa.d_addr = '0; ifa.d_wdata = '0; ifa.d_wstrb = '0;
    ifa.i_req = 0; ifa.i_addr = '0; ifa.mem_rdata = '0;
    ifb.d_req = 0; ifb.d_we = 0; ifb.d_addr = '0; ifb.d_wdata = '0; ifb.d_wstrb = '0;
    ifb.i_req = 0; ifb.i_addr = '0; ifb.mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    ifa.d_req = 1; ifa.i_req = 1; ifa.d_addr = 64'h40; ifa.i_addr = 64'h80;
    step(); #1;
    checks++; if (ifa.d_gnt !== 1'b0 || ifa.i_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got d=%b i=%b want 0", ifa.d_gnt, ifa.i_gnt); end
    checks++; if (ifa.mem_en !== 1'b0 || ifa.mem_addr !== 64'h0) begin errors++; $display("FAIL reset_mem got en=%b addr=%h want 0", ifa.mem_en, ifa.mem_addr); end
    checks++; if (ifa.d_rvalid !== 1'b0 || ifa.i_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got d=%b i=%b want 0", ifa.d_rvalid, ifa.i_rvalid); end
    step();
    rst = 0;
    clear_inputs();
    #1;
    checks++; if ({ifa.mem_en, ifa.mem_we, ifa.mem_wstrb} !== 10'h0 || ifa.mem_addr !== 64'h0 || ifa.mem_wdata !== 64'h0) begin errors++; $display("FAIL idle_mem got en=%b we=%b strb=%h addr=%h want 0", ifa.mem_en, ifa.mem_we, ifa.mem_wstrb, ifa.mem_addr); end
    checks++; if (ifa.d_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", ifa.d_rdata); end
  endtask

  task automatic test_fetch_read();
    step();
    ifa.i_req = 1; ifa.i_addr = 64'h8000_0010;
    #1;
    checks++; if (ifa.i_gnt !== 1'b1 || ifa.mem_en !== 1'b1 || ifa.d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt got i=%b en=%b d=%b want 1 1 0", ifa.i_gnt, ifa.mem_en, ifa.d_gnt); end
    checks++; if (ifa.mem_addr !== 64'h8000_0010 || ifa.mem_we !== 1'b0 || ifa.mem_wstrb !== 8'h0) begin errors++; $display("FAIL fetch_mem got addr=%h we=%b strb=%h", ifa.mem_addr, ifa.mem_we, ifa.mem_wstrb); end
    step();
    ifa.i_req = 0; ifa.mem_rdata = 64'h1122_3344_5566_7788;
    #1;
    checks++; if (ifa.i_gnt !== 1'b0 || ifa.mem_en !== 1'b0 || ifa.i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_wait got gnt=%b en=%b rv=%b want 0", ifa.i_gnt, ifa.mem_en, ifa.i_rvalid); end
    step();
    ifa.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    checks++; if (ifa.i_rvalid !== 1'b1 || ifa.d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid got i=%b d=%b want 1 0", ifa.i_rvalid, ifa.d_rvalid); end
    checks++; if (ifa.i_rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL fetch_rdata got %h want 1122334455667788", ifa.i_rdata); end
    step(); #1;
    checks++; if (ifa.i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_once got %b want 0", ifa.i_rvalid); end
    checks++; if (ifa.i_rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL fetch_rdata_hold got %h want 1122334455667788", ifa.i_rdata); end
  endtask

  task automatic test_write();
    step();
    ifa.d_req = 1; ifa.d_we = 1; ifa.d_addr = 64'h8; ifa.d_wstrb = 8'h04; ifa.d_wdata = 64'hAB_0000;
    #1;
    checks++; if (ifa.d_gnt !== 1'b1 || ifa.mem_en !== 1'b1 || ifa.mem_we !== 1'b1) begin errors++; $display("FAIL write_gnt got gnt=%b en=%b we=%b want 1", ifa.d_gnt, ifa.mem_en, ifa.mem_we); end
    checks++; if (ifa.mem_wstrb !== 8'h04 || ifa.mem_addr !== 64'h8 || ifa.mem_wdata !== 64'hAB_0000) begin errors++; $display("FAIL write_mem got strb=%h addr=%h data=%h", ifa.mem_wstrb, ifa.mem_addr, ifa.mem_wdata); end
    step();
    ifa.d_addr = 64'h10; ifa.d_wstrb = 8'h81; ifa.d_wdata = 64'h7700_0000_0000_0066;
    #1;
    checks++; if (ifa.d_gnt !== 1'b1 || ifa.mem_addr !== 64'h10 || ifa.mem_wstrb !== 8'h81) begin errors++; $display("FAIL write_b2b got gnt=%b addr=%h strb=%h", ifa.d_gnt, ifa.mem_addr, ifa.mem_wstrb); end
    checks++; if (ifa.d_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid1 got %b want 0", ifa.d_rvalid); end
    step();
    clear_inputs();
    #1;
    checks++; if (ifa.d_rvalid !== 1'b0 || ifa.mem_en !== 1'b0 || ifa.mem_wdata !== 64'h0) begin errors++; $display("FAIL write_after got rv=%b en=%b wdata=%h want 0", ifa.d_rvalid, ifa.mem_en, ifa.mem_wdata); end
  endtask

  task automatic test_starvation();
    int n;
    logic exp_i;
    n = 0;
    step();
    ifa.d_req = 1; ifa.d_we = 1; ifa.d_addr = 64'h200; ifa.d_wstrb = 8'hF0; ifa.d_wdata = 64'h5555;
    ifa.i_req = 1; ifa.i_addr = 64'h300;
    for (int cyc = 0; cyc < 30 && n < 10; cyc++) begin
      #1;
      if (ifa.d_gnt === 1'b1 && ifa.i_gnt === 1'b1) begin
        checks++; errors++; $display("FAIL starve_both grant #%0d", n);
      end else if (ifa.d_gnt === 1'b1 || ifa.i_gnt === 1'b1) begin
        exp_i = (n == 4 || n == 9);
        checks++; if (ifa.i_gnt !== exp_i) begin errors++; $display("FAIL starve_seq grant #%0d got i_gnt=%b want %b", n, ifa.i_gnt, exp_i); end
        if (exp_i) begin
          checks++; if (ifa.mem_addr !== 64'h300 || ifa.mem_we !== 1'b0 || ifa.mem_wstrb !== 8'h0 || ifa.mem_wdata !== 64'h0) begin errors++; $display("FAIL starve_fetch_mem got addr=%h we=%b strb=%h data=%h", ifa.mem_addr, ifa.mem_we, ifa.mem_wstrb, ifa.mem_wdata); end
        end
        n++;
      end
      step();
    end
    checks++; if (n != 10) begin errors++; $display("FAIL starve_count got %0d grants want 10", n); end
    clear_inputs();
    repeat (4) step();
  endtask

  task automatic test_lat3();
    logic [63:0] rd;
    step();
    ifb.d_req = 1; ifb.d_we = 0; ifb.d_addr = 64'h40; ifb.d_wstrb = 8'hFF; ifb.d_wdata = 64'h55;
    #1;
    checks++; if (ifb.d_gnt !== 1'b1 || ifb.mem_we !== 1'b0 || ifb.mem_wstrb !== 8'h0 || ifb.mem_addr !== 64'h40) begin errors++; $display("FAIL lat3_gnt got gnt=%b we=%b strb=%h addr=%h", ifb.d_gnt, ifb.mem_we, ifb.mem_wstrb, ifb.mem_addr); end
    for (int i = 1; i <= 4; i++) begin
      step();
      ifb.d_req = 0; ifb.i_req = 1; ifb.i_addr = 64'h500;
      rd = 64'hA000_0000_0000_0000 + 64'(i);
      ifb.mem_rdata = rd;
      #1;
      checks++; if ({ifb.d_gnt, ifb.i_gnt, ifb.mem_en} !== 3'b000) begin errors++; $display("FAIL lat3_nogrant T+%0d got d=%b i=%b en=%b want 0", i, ifb.d_gnt, ifb.i_gnt, ifb.mem_en); end
      checks++; if (ifb.d_rvalid !== (i == 4) || ifb.i_rvalid !== 1'b0) begin errors++; $display("FAIL lat3_rvalid T+%0d got d=%b i=%b", i, ifb.d_rvalid, ifb.i_rvalid); end
      if (i == 4) begin
        checks++; if (ifb.d_rdata !== 64'hA000_0000_0000_0003) begin errors++; $display("FAIL lat3_rdata got %h want a000000000000003", ifb.d_rdata); end
      end
    end
    step(); #1;
    checks++; if (ifb.i_gnt !== 1'b1 || ifb.mem_addr !== 64'h500) begin errors++; $display("FAIL lat3_pending got i_gnt=%b addr=%h want 1 500", ifb.i_gnt, ifb.mem_addr); end
    step();
    clear_inputs();
    repeat (5) step();
  endtask

  task automatic test_reset_mid_read();
    step();
    ifa.d_req = 1; ifa.d_we = 0; ifa.d_addr = 64'h900;
    #1;
    checks++; if (ifa.d_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b want 1", ifa.d_gnt); end
    step();
    ifa.d_req = 0; rst = 1;
    #1;
    checks++; if (ifa.d_rvalid !== 1'b0 || ifa.mem_en !== 1'b0) begin errors++; $display("FAIL rmid_in_reset got rv=%b en=%b want 0", ifa.d_rvalid, ifa.mem_en); end
    step();
    rst = 0; ifa.i_req = 1; ifa.i_addr = 64'h100;
    #1;
    checks++; if (ifa.i_gnt !== 1'b1 || ifa.d_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_regrant got i_gnt=%b d_rv=%b want 1 0", ifa.i_gnt, ifa.d_rvalid); end
    step();
    ifa.i_req = 0;
    #1;
    checks++; if (ifa.d_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_no_rvalid3 got %b want 0", ifa.d_rvalid); end
    step(); #1;
    checks++; if (ifa.d_rvalid !== 1'b0 || ifa.i_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_owner got d=%b i=%b want 0 1", ifa.d_rvalid, ifa.i_rvalid); end
    step();
  endtask

  task automatic test_resp_simultaneous();
    step();
    ifa.d_req = 1; ifa.d_we = 0; ifa.d_addr = 64'hA00;
    #1;
    checks++; if (ifa.d_gnt !== 1'b1) begin errors++; $display("FAIL resp_read_gnt got %b want 1", ifa.d_gnt); end
    step();
    ifa.d_req = 0;
    step();
    ifa.d_req = 1; ifa.d_we = 1; ifa.d_addr = 64'hB00; ifa.d_wstrb = 8'h01;
    ifa.i_req = 1; ifa.i_addr = 64'hC00;
    #1;
    checks++; if (ifa.d_rvalid !== 1'b1 || ifa.d_gnt !== 1'b0 || ifa.i_gnt !== 1'b0) begin errors++; $display("FAIL resp_cycle got rv=%b d=%b i=%b want 1 0 0", ifa.d_rvalid, ifa.d_gnt, ifa.i_gnt); end
    step(); #1;
    checks++; if (ifa.d_gnt !== 1'b1 || ifa.i_gnt !== 1'b0 || ifa.mem_addr !== 64'hB00) begin errors++; $display("FAIL resp_next_idle got d=%b i=%b addr=%h want 1 0 b00", ifa.d_gnt, ifa.i_gnt, ifa.mem_addr); end
    step();
    clear_inputs();
    repeat (3) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fetch_read();
    test_write();
    test_starvation();
    test_lat3();
    test_reset_mid_read();
    test_resp_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
